// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and counter widths for the character
// display timing generator.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam bit DEF_SYNC_POL   = 1'b0;
    localparam int DEF_PIPE_DELAY = 2;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int H_COUNT_W = 11;
    localparam int V_COUNT_W = 10;
    localparam int CHAR_W    = 7;
    localparam int SUB_W     = 3;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth register chain with a synchronous clear to a chosen idle value.
// Depth must be at least 1; zero-depth paths are handled by the instantiator.
module sync_delay_line #(
    parameter int               DEPTH       = 2,
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             pixel_clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge pixel_clock) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VALUE;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_char_timing.sv
// VGA raster timing with character-cell coordinates; sync/blank/frame pulse are
// delayed to match the downstream character RAM + glyph ROM read latency.
module vga_char_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_POL   = DEF_SYNC_POL,
    parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic                 pixel_clock,
    input  logic                 reset,
    input  logic                 timing_en,
    output logic [CHAR_W-1:0]    char_column,
    output logic [CHAR_W-1:0]    char_line,
    output logic [SUB_W-1:0]     subchar_pixel,
    output logic [SUB_W-1:0]     subchar_line,
    output logic [H_COUNT_W-1:0] h_count,
    output logic [V_COUNT_W-1:0] v_count,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 blank,
    output logic                 frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_COUNT_W-1:0] H_LAST   = H_COUNT_W'(H_TOTAL - 1);
    localparam logic [H_COUNT_W-1:0] H_VIS    = H_COUNT_W'(H_ACTIVE);
    localparam logic [H_COUNT_W-1:0] HS_START = H_COUNT_W'(H_ACTIVE + H_FP);
    localparam logic [H_COUNT_W-1:0] HS_END   = H_COUNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_COUNT_W-1:0] V_LAST   = V_COUNT_W'(V_TOTAL - 1);
    localparam logic [V_COUNT_W-1:0] V_VIS    = V_COUNT_W'(V_ACTIVE);
    localparam logic [V_COUNT_W-1:0] VS_START = V_COUNT_W'(V_ACTIVE + V_FP);
    localparam logic [V_COUNT_W-1:0] VS_END   = V_COUNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [3:0] IDLE_VALUE = {~SYNC_POL, ~SYNC_POL, 1'b1, 1'b0};

    logic       idle;
    logic       running;
    logic       hs_active;
    logic       vs_active;
    logic [3:0] raw_bundle;
    logic [3:0] delayed_bundle;

    assign idle = reset || !timing_en;

    // The first enabled edge only arms 'running' so that h=0,v=0 is a real
    // displayed cycle whose frame pulse enters the delay line.
    always_ff @(posedge pixel_clock) begin
        if (idle) begin
            running       <= 1'b0;
            h_count       <= '0;
            v_count       <= '0;
            char_column   <= '0;
            subchar_pixel <= '0;
            char_line     <= '0;
            subchar_line  <= '0;
        end else if (!running) begin
            running <= 1'b1;
        end else if (h_count == H_LAST) begin
            h_count       <= '0;
            char_column   <= '0;
            subchar_pixel <= '0;
            if (v_count == V_LAST) begin
                v_count      <= '0;
                char_line    <= '0;
                subchar_line <= '0;
            end else begin
                v_count <= v_count + 1'b1;
                if (&subchar_line) begin
                    subchar_line <= '0;
                    char_line    <= char_line + 1'b1;
                end else begin
                    subchar_line <= subchar_line + 1'b1;
                end
            end
        end else begin
            h_count <= h_count + 1'b1;
            if (&subchar_pixel) begin
                subchar_pixel <= '0;
                char_column   <= char_column + 1'b1;
            end else begin
                subchar_pixel <= subchar_pixel + 1'b1;
            end
        end
    end

    always_comb begin
        hs_active     = running && (h_count >= HS_START) && (h_count < HS_END);
        vs_active     = running && (v_count >= VS_START) && (v_count < VS_END);
        raw_bundle[3] = hs_active ? SYNC_POL : ~SYNC_POL;
        raw_bundle[2] = vs_active ? SYNC_POL : ~SYNC_POL;
        raw_bundle[1] = !running || (h_count >= H_VIS) || (v_count >= V_VIS);
        raw_bundle[0] = running && (h_count == '0) && (v_count == '0);
    end

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign delayed_bundle = raw_bundle;
        end else begin : g_delay
            sync_delay_line #(
                .DEPTH       (PIPE_DELAY),
                .WIDTH       (4),
                .RESET_VALUE (IDLE_VALUE)
            ) u_sync_delay (
                .pixel_clock (pixel_clock),
                .clear       (idle),
                .din         (raw_bundle),
                .dout        (delayed_bundle)
            );
        end
    endgenerate

    assign {hsync, vsync, blank, frame_start} = delayed_bundle;

endmodule

// File: tb/tb_vga_char_timing.sv
// Bench for vga_char_timing: three builds (default, zero-delay/positive sync,
// narrow-line) driven together and compared every cycle with a raster model.
module tb_vga_char_timing;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, pd;
        bit pol;
    } cfg_t;

    typedef struct packed {
        logic [6:0]  cc;
        logic [6:0]  cl;
        logic [2:0]  sp;
        logic [2:0]  sl;
        logic [10:0] h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fs;
    } obs_t;

    logic pixel_clock = 1'b0;
    logic reset       = 1'b1;
    logic timing_en   = 1'b0;

    logic [6:0]  cc [3];
    logic [6:0]  cl [3];
    logic [2:0]  sp [3];
    logic [2:0]  sl [3];
    logic [10:0] hc [3];
    logic [9:0]  vc [3];
    logic        hs [3];
    logic        vs [3];
    logic        bl [3];
    logic        fs [3];

    cfg_t   cfgs [3];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    bit     model_run = 1'b0;
    longint model_t = 0;

    always #5 pixel_clock = ~pixel_clock;

    vga_char_timing dut_a (
        .pixel_clock(pixel_clock), .reset(reset), .timing_en(timing_en),
        .char_column(cc[0]), .char_line(cl[0]), .subchar_pixel(sp[0]), .subchar_line(sl[0]),
        .h_count(hc[0]), .v_count(vc[0]), .hsync(hs[0]), .vsync(vs[0]),
        .blank(bl[0]), .frame_start(fs[0])
    );

    vga_char_timing #(.SYNC_POL(1'b1), .PIPE_DELAY(0)) dut_b (
        .pixel_clock(pixel_clock), .reset(reset), .timing_en(timing_en),
        .char_column(cc[1]), .char_line(cl[1]), .subchar_pixel(sp[1]), .subchar_line(sl[1]),
        .h_count(hc[1]), .v_count(vc[1]), .hsync(hs[1]), .vsync(vs[1]),
        .blank(bl[1]), .frame_start(fs[1])
    );

    vga_char_timing #(.H_ACTIVE(8), .H_FP(8), .H_SYNC(8), .H_BP(8)) dut_c (
        .pixel_clock(pixel_clock), .reset(reset), .timing_en(timing_en),
        .char_column(cc[2]), .char_line(cl[2]), .subchar_pixel(sp[2]), .subchar_line(sl[2]),
        .h_count(hc[2]), .v_count(vc[2]), .hsync(hs[2]), .vsync(vs[2]),
        .blank(bl[2]), .frame_start(fs[2])
    );

    // Expected outputs from elapsed running time t; delayed signals look back pd cycles.
    function automatic obs_t model(input cfg_t c, input bit run, input longint t);
        obs_t   e;
        longint ht, vt, h, v, hd, vd;
        ht   = c.ha + c.hf + c.hs + c.hb;
        vt   = c.va + c.vf + c.vs + c.vb;
        e    = '0;
        e.hs = ~c.pol;
        e.vs = ~c.pol;
        e.bl = 1'b1;
        if (run) begin
            h    = t % ht;
            v    = (t / ht) % vt;
            e.h  = 11'(h);
            e.v  = 10'(v);
            e.cc = 7'(h / 8);
            e.sp = 3'(h % 8);
            e.cl = 7'(v / 8);
            e.sl = 3'(v % 8);
            if (t >= c.pd) begin
                hd   = (t - c.pd) % ht;
                vd   = ((t - c.pd) / ht) % vt;
                e.hs = (hd >= c.ha + c.hf && hd < c.ha + c.hf + c.hs) ? c.pol : ~c.pol;
                e.vs = (vd >= c.va + c.vf && vd < c.va + c.vf + c.vs) ? c.pol : ~c.pol;
                e.bl = (hd >= c.ha) || (vd >= c.va);
                e.fs = (hd == 0) && (vd == 0);
            end
        end
        return e;
    endfunction

    task automatic finish_up();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        obs_t got, exp_v;
        for (int i = 0; i < 3; i++) begin
            exp_v  = model(cfgs[i], model_run, model_t);
            got.cc = cc[i]; got.cl = cl[i]; got.sp = sp[i]; got.sl = sl[i];
            got.h  = hc[i]; got.v  = vc[i]; got.hs = hs[i]; got.vs = vs[i];
            got.bl = bl[i]; got.fs = fs[i];
            checks++;
            assert (got === exp_v) else begin
                errors++;
                $error("[TB] FAIL model_dut%0d cycle %0d: observed %h expected %h", i, cyc, got, exp_v);
            end
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare on the falling edge.
    task automatic applyStimulus(input bit r, input bit e);
        reset     = r;
        timing_en = e;
        @(posedge pixel_clock);
        if (r || !e) begin
            model_run = 1'b0;
            model_t   = 0;
        end else if (!model_run) begin
            model_run = 1'b1;
            model_t   = 0;
        end else begin
            model_t++;
        end
        cyc++;
        @(negedge pixel_clock);
        checkOutput();
        if (errors > 20) begin
            $display("[TB] too many errors, stopping early");
            finish_up();
        end
    endtask

    task automatic run_until(input int idx, input int h, input int v, input int limit, input string tag);
        int  n;
        bit  found;
        n     = 0;
        found = (hc[idx] == 11'(h)) && (v < 0 || vc[idx] == 10'(v));
        while (!found && n < limit) begin
            applyStimulus(1'b0, 1'b1);
            n++;
            found = (hc[idx] == 11'(h)) && (v < 0 || vc[idx] == 10'(v));
        end
        check_value({"reach_", tag}, 32'(found), 32'd1);
    endtask

    initial begin
        int          n;
        longint      fall_cyc;
        logic        prev;
        logic [2:0]  prev_sl;
        longint      fs_times[$];
        int          vs_lows[$];
        longint      vs_fall;
        bit          seen_479;

        cfgs[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0};
        cfgs[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 1'b1};
        cfgs[2] = '{8, 8, 8, 8, 480, 10, 2, 33, 2, 1'b0};
        $display("[TB] starting vga_char_timing bench");

        @(negedge pixel_clock);
        repeat (3) applyStimulus(1'b1, 1'b1);
        check_value("rst_hsync", 32'(hs[0]), 32'd1);
        check_value("rst_vsync", 32'(vs[0]), 32'd1);
        check_value("rst_blank", 32'(bl[0]), 32'd1);
        check_value("rst_frame", 32'(fs[0]), 32'd0);
        check_value("rst_hcount", 32'(hc[0]), 32'd0);
        check_value("rst_vcount", 32'(vc[0]), 32'd0);
        check_value("rst_hsync_pos", 32'(hs[1]), 32'd0);

        applyStimulus(1'b0, 1'b1);
        check_value("start_frame_c0", 32'(fs[0]), 32'd0);
        check_value("pd0_frame_c0", 32'(fs[1]), 32'd1);
        check_value("pd0_blank_c0", 32'(bl[1]), 32'd0);
        check_value("pd0_col_c0", 32'(cc[1]), 32'd0);
        applyStimulus(1'b0, 1'b1);
        check_value("start_frame_c1", 32'(fs[0]), 32'd0);
        applyStimulus(1'b0, 1'b1);
        check_value("start_frame_c2", 32'(fs[0]), 32'd1);

        run_until(0, 13, 0, 50, "h13");
        check_value("h13_col", 32'(cc[0]), 32'd1);
        check_value("h13_subpix", 32'(sp[0]), 32'd5);

        run_until(0, 641, 0, 1000, "h641");
        check_value("blank_h641", 32'(bl[0]), 32'd0);
        applyStimulus(1'b0, 1'b1);
        check_value("blank_h642", 32'(bl[0]), 32'd1);

        run_until(0, 657, 0, 100, "h657");
        check_value("hsync_h657", 32'(hs[0]), 32'd1);
        applyStimulus(1'b0, 1'b1);
        check_value("hsync_h658", 32'(hs[0]), 32'd0);
        fall_cyc = cyc;
        n = 1;
        while (hs[0] === 1'b0 && n < 2000) begin
            applyStimulus(1'b0, 1'b1);
            if (hs[0] === 1'b0) n++;
            else break;
        end
        check_value("hsync_low_len", 32'(n), 32'd96);
        prev = hs[0];
        n = 0;
        while (!(prev === 1'b1 && hs[0] === 1'b0) && n < 2000) begin
            prev = hs[0];
            applyStimulus(1'b0, 1'b1);
            n++;
        end
        check_value("hsync_period", 32'(cyc - fall_cyc), 32'd800);

        run_until(0, 799, 1, 1000, "h799");
        prev_sl = sl[0];
        applyStimulus(1'b0, 1'b1);
        check_value("wrap_col", 32'(cc[0]), 32'd0);
        check_value("wrap_subpix", 32'(sp[0]), 32'd0);
        check_value("wrap_subline", 32'(sl[0]), 32'(prev_sl + 3'd1));
        applyStimulus(1'b0, 1'b1);
        check_value("blank_h1", 32'(bl[0]), 32'd1);
        applyStimulus(1'b0, 1'b1);
        check_value("blank_h2", 32'(bl[0]), 32'd0);

        for (int k = 0; k < 20; k++) begin
            int  run_len, idle_len;
            bit  use_reset;
            run_len   = int'($urandom_range(10, 400));
            idle_len  = int'($urandom_range(1, 5));
            use_reset = 1'($urandom_range(0, 1));
            repeat (run_len) applyStimulus(1'b0, 1'b1);
            repeat (idle_len) applyStimulus(use_reset, use_reset ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        applyStimulus(1'b1, 1'b1);
        run_until(0, 300, 2, 3000, "h300v2");
        applyStimulus(1'b0, 1'b0);
        check_value("en_off_h", 32'(hc[0]), 32'd0);
        check_value("en_off_v", 32'(vc[0]), 32'd0);
        check_value("en_off_hsync", 32'(hs[0]), 32'd1);
        check_value("en_off_blank", 32'(bl[0]), 32'd1);
        check_value("en_off_pd0_hsync", 32'(hs[1]), 32'd0);
        repeat (49) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        check_value("en_on_h", 32'(hc[0]), 32'd0);
        check_value("en_on_pd0_frame", 32'(fs[1]), 32'd1);
        applyStimulus(1'b0, 1'b1);
        check_value("en_on_frame_c1", 32'(fs[0]), 32'd0);
        applyStimulus(1'b0, 1'b1);
        check_value("en_on_frame_c2", 32'(fs[0]), 32'd1);

        run_until(1, 700, 0, 1000, "pd0_h700");
        check_value("pd0_hsync_active", 32'(hs[1]), 32'd1);
        check_value("dflt_hsync_active", 32'(hs[0]), 32'd0);
        applyStimulus(1'b1, 1'b0);
        check_value("midrst_pd0_hsync", 32'(hs[1]), 32'd0);
        check_value("midrst_dflt_hsync", 32'(hs[0]), 32'd1);
        check_value("midrst_h", 32'(hc[1]), 32'd0);

        seen_479 = 1'b0;
        prev     = vs[2];
        vs_fall  = 0;
        for (int k = 0; k < 33620; k++) begin
            applyStimulus(1'b0, 1'b1);
            if (fs[2] === 1'b1) fs_times.push_back(cyc);
            if (prev === 1'b1 && vs[2] === 1'b0) vs_fall = cyc;
            if (prev === 1'b0 && vs[2] === 1'b1) vs_lows.push_back(int'(cyc - vs_fall));
            prev = vs[2];
            if (!seen_479 && vc[2] == 10'd479) begin
                seen_479 = 1'b1;
                check_value("v479_line", 32'(cl[2]), 32'd59);
                check_value("v479_subline", 32'(sl[2]), 32'd7);
            end
        end
        check_value("frame_pulses", 32'(fs_times.size()), 32'd3);
        if (fs_times.size() >= 3) begin
            check_value("frame_period_1", 32'(fs_times[1] - fs_times[0]), 32'd16800);
            check_value("frame_period_2", 32'(fs_times[2] - fs_times[1]), 32'd16800);
        end
        check_value("vsync_pulses", 32'(vs_lows.size()), 32'd2);
        if (vs_lows.size() >= 1) check_value("vsync_low_len", 32'(vs_lows[0]), 32'd64);

        finish_up();
    end

endmodule

// File: doc/vga_char_timing.md
Name: vga_char_timing

Overview:
- Upstream timing generator for the character display stage; runs on `pixel_clock`.
- Produces VGA sync and blanking signals.
- Produces the character-cell coordinates (`char_column`, `char_line`, `subchar_line`, `subchar_pixel`) that address character RAM and the glyph ROM.
- Sync, blank and frame pulse are delayed to line up with the display stage's RAM+ROM read latency. This keeps RGB, sync and blank aligned at the connector.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- PIPE_DELAY, 2, extra cycles applied to hsync/vsync/blank/frame_start relative to the char coordinates (>=0)

Ports:
- pixel_clock  in  1  pixel clock; only clock
- reset  in  1  synchronous, active-high
- timing_en  in  1  run enable; low holds the generator idle
- char_column  out  7  h_count / 8
- char_line  out  7  v_count / 8
- subchar_pixel  out  3  h_count mod 8
- subchar_line  out  3  v_count mod 8
- h_count  out  11  raw pixel counter
- v_count  out  10  raw line counter
- hsync  out  1  delayed horizontal sync
- vsync  out  1  delayed vertical sync
- blank  out  1  delayed; high outside active area
- frame_start  out  1  delayed one-cycle pulse at h=0, v=0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL (default 525).
- h_count increments every enabled cycle and wraps H_TOTAL-1 -> 0. v_count increments on the h wrap and wraps V_TOTAL-1 -> 0.
- Char counters are incremental registers, not dividers:
  - subchar_pixel increments with h_count; at 7 it wraps to 0 and char_column increments.
  - At h wrap, char_column and subchar_pixel go to 0.
  - subchar_line / char_line follow the same rule on v_count, stepping only on h wrap; at v wrap both go to 0.
  - Invariant every cycle: char_column == h_count[9:3]; char_line == v_count[9:3].
  - Counters run through blanking; max char_column 99, max char_line 65 (fit in 7 bits).
- Raw sync/blank are computed from the current counters (not from the delay line):
  - hsync active for H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync active for 490..491.
  - blank = (h_count >= H_ACTIVE) or (v_count >= V_ACTIVE).
  - frame_start = (h_count==0 && v_count==0).
- Output timing:
  - Counter/char outputs are registered; they reflect counter state, 0 cycles of delay after the register.
  - hsync/vsync/blank/frame_start pass through a PIPE_DELAY-stage register chain. PIPE_DELAY=0 means same cycle as the char outputs.
  - Sync polarity: pin = SYNC_POL when active, ~SYNC_POL when inactive.
- Reset (any time, including mid-frame): next edge sets every counter to 0 and flushes every delay stage to the inactive value.
  - Reset values: hsync=vsync=~SYNC_POL, blank=1, frame_start=0, all counts 0.
- timing_en low: same as reset, held while low; counters frozen at 0, delay line flushed inactive.
  - On the first enabled edge, counters start from h=0, v=0.
  - frame_start appears PIPE_DELAY cycles after the first enabled cycle.
- reset has priority over timing_en.
- Simultaneous wraps at h=H_TOTAL-1, v=V_TOTAL-1: all counters go to 0 on the same edge; frame_start is raised for the new h=0, v=0 cycle.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 default timing constants.
  - Derived H_TOTAL/V_TOTAL.
  - Counter width constants (11/10/7/3).
- One sub-module, sync_delay_line:
  - Parameterized depth and width; synchronous clear to a parameter reset value.
  - Instantiated once for {hsync, vsync, blank, frame_start}.

Test Plan:
- Reset check: assert reset 3 cycles -> hsync=vsync=1, blank=1, frame_start=0, all counts 0; release -> frame_start pulse exactly PIPE_DELAY cycles later (default: cycle 2).
- Horizontal timing: after release, measure hsync -> low for 96 clocks starting PIPE_DELAY after h_count=656; period 800 clocks; blank high for h=640..799 (delayed by 2).
- Vertical timing: run 2 full frames -> vsync low for 1600 clocks at lines 490-491; frame_start period 420000 clocks.
- Char coordinates:
  - h=13, v=0 -> char_column=1, subchar_pixel=5.
  - v=479 -> char_line=59, subchar_line=7.
  - h 799->0 -> char_column=0, subchar_pixel=0, subchar_line increments.
  - Scoreboard the invariant every cycle for 2 frames.
- Enable gating: drop timing_en at h=300, v=100 -> next edge all counts 0, sync inactive, blank=1 (flushed, not delayed); raise after 50 cycles -> restart from 0,0, frame_start after PIPE_DELAY cycles.
- Mid-frame reset and PIPE_DELAY=0 build: reset at h=700, v=491 (sync active) -> next edge sync inactive; with PIPE_DELAY=0, blank falls on the same cycle as char_column=0 at v=0.
